// File: rtl/exec_result_stage_pkg.sv
// Shared widths, instruction-kind / branch codes and the packed result beat
// for the execute result stage.
package exec_result_stage_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_WIDTH      = 5;
    localparam int unsigned KIND_WIDTH     = 2;
    localparam int unsigned FUNCT3_WIDTH   = 3;
    localparam int unsigned ALU_COMP_WIDTH = 3;

    // Bit positions inside the ALU comparison flag vector
    localparam int unsigned ALU_COMP_EQ  = 0;
    localparam int unsigned ALU_COMP_LT  = 1;
    localparam int unsigned ALU_COMP_LTU = 2;

    typedef enum logic [KIND_WIDTH-1:0] {
        KIND_NONE   = 2'd0,
        KIND_ALU    = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_JUMP   = 2'd3
    } kind_e;

    localparam logic [FUNCT3_WIDTH-1:0] BR_FUNCT3_BEQ  = 3'b000;
    localparam logic [FUNCT3_WIDTH-1:0] BR_FUNCT3_BNE  = 3'b001;
    localparam logic [FUNCT3_WIDTH-1:0] BR_FUNCT3_BLT  = 3'b100;
    localparam logic [FUNCT3_WIDTH-1:0] BR_FUNCT3_BGE  = 3'b101;
    localparam logic [FUNCT3_WIDTH-1:0] BR_FUNCT3_BLTU = 3'b110;
    localparam logic [FUNCT3_WIDTH-1:0] BR_FUNCT3_BGEU = 3'b111;

    typedef struct packed {
        logic                  rd_en;
        logic [REG_WIDTH-1:0]  rd_addr;
        logic [DATA_WIDTH-1:0] rd_din;
        logic                  redirect;
        logic [DATA_WIDTH-1:0] target;
        logic                  misaligned;
    } result_t;

    localparam int unsigned RESULT_WIDTH = $bits(result_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Branch condition evaluation; reserved funct3 codes never take
    function automatic logic branch_taken(
        input logic [FUNCT3_WIDTH-1:0]   funct3,
        input logic [ALU_COMP_WIDTH-1:0] comp
    );
        logic taken;
        taken = 1'b0;
        case (funct3)
            BR_FUNCT3_BEQ:  taken =  comp[ALU_COMP_EQ];
            BR_FUNCT3_BNE:  taken = ~comp[ALU_COMP_EQ];
            BR_FUNCT3_BLT:  taken =  comp[ALU_COMP_LT];
            BR_FUNCT3_BGE:  taken = ~comp[ALU_COMP_LT];
            BR_FUNCT3_BLTU: taken =  comp[ALU_COMP_LTU];
            BR_FUNCT3_BGEU: taken = ~comp[ALU_COMP_LTU];
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exec_result_stage_if.sv
// Upstream (ALU + instruction context) and downstream (writeback/fetch)
// handshake bundle of the execute result stage.
interface exec_result_stage_if;
    import exec_result_stage_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_alu_dout;
    logic [ALU_COMP_WIDTH-1:0] in_alu_comp;
    logic [DATA_WIDTH-1:0]     in_pc;
    logic [DATA_WIDTH-1:0]     in_imm;
    logic [REG_WIDTH-1:0]      in_rd;
    logic [KIND_WIDTH-1:0]     in_kind;
    logic [FUNCT3_WIDTH-1:0]   in_funct3;

    logic                      out_valid;
    logic                      out_ready;
    logic                      out_rd_en;
    logic [REG_WIDTH-1:0]      out_rd_addr;
    logic [DATA_WIDTH-1:0]     out_rd_din;
    logic                      out_redirect;
    logic [DATA_WIDTH-1:0]     out_target;
    logic                      out_misaligned;

    // Environment side: produces instructions, consumes results
    modport master (
        output in_valid, in_alu_dout, in_alu_comp, in_pc, in_imm, in_rd,
               in_kind, in_funct3, out_ready,
        input  in_ready, out_valid, out_rd_en, out_rd_addr, out_rd_din,
               out_redirect, out_target, out_misaligned
    );

    // Stage side
    modport slave (
        input  in_valid, in_alu_dout, in_alu_comp, in_pc, in_imm, in_rd,
               in_kind, in_funct3, out_ready,
        output in_ready, out_valid, out_rd_en, out_rd_addr, out_rd_din,
               out_redirect, out_target, out_misaligned
    );

endinterface

// File: rtl/exec_result_stage_branch_resolver.sv
// Combinational mapping of one ALU beat plus instruction context to the
// packed register-write / redirect result.
module exec_result_stage_branch_resolver
    import exec_result_stage_pkg::*;
(
    input  logic [KIND_WIDTH-1:0]     i_kind,
    input  logic [FUNCT3_WIDTH-1:0]   i_funct3,
    input  logic [ALU_COMP_WIDTH-1:0] i_alu_comp,
    input  logic [DATA_WIDTH-1:0]     i_alu_dout,
    input  logic [DATA_WIDTH-1:0]     i_pc,
    input  logic [DATA_WIDTH-1:0]     i_imm,
    input  logic [REG_WIDTH-1:0]      i_rd,
    output result_t                   o_result_c
);

    logic [DATA_WIDTH-1:0] w_pc_plus_imm;
    logic [DATA_WIDTH-1:0] w_pc_plus_4;
    logic [DATA_WIDTH-1:0] w_jump_target;
    logic                  w_rd_nonzero;
    logic                  w_taken;

    // Sums wrap at DATA_WIDTH
    assign w_pc_plus_imm = DATA_WIDTH'(i_pc + i_imm);
    assign w_pc_plus_4   = DATA_WIDTH'(i_pc + DATA_WIDTH'(4));
    assign w_jump_target = i_alu_dout & ~DATA_WIDTH'(1);
    assign w_rd_nonzero  = (i_rd != REG_WIDTH'(0));
    assign w_taken       = branch_taken(i_funct3, i_alu_comp);

    always_comb begin
        o_result_c         = '0;
        o_result_c.rd_addr = i_rd;
        case (kind_e'(i_kind))
            KIND_ALU: begin
                o_result_c.rd_en  = w_rd_nonzero;
                o_result_c.rd_din = i_alu_dout;
            end
            KIND_BRANCH: begin
                o_result_c.redirect = w_taken;
                o_result_c.target   = w_pc_plus_imm;
            end
            KIND_JUMP: begin
                o_result_c.rd_en    = w_rd_nonzero;
                o_result_c.rd_din   = w_pc_plus_4;
                o_result_c.redirect = 1'b1;
                o_result_c.target   = w_jump_target;
            end
            default: begin
                o_result_c.rd_en = 1'b0;
            end
        endcase
        // Misalignment is flagged but the redirect still goes out; control traps
        o_result_c.misaligned = o_result_c.redirect & (o_result_c.target[1:0] != 2'b00);
    end

endmodule

// File: rtl/exec_result_stage.sv
// Execute result stage: resolves branches/jumps and presents one registered
// result beat per instruction through a 2-entry skid buffer.
module exec_result_stage
    import exec_result_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    exec_result_stage_if.slave  bus
);

    state_e  r_state;
    state_e  w_state_nxt;
    result_t r_main;
    result_t r_skid;
    result_t w_main_nxt;
    result_t w_skid_nxt;
    result_t w_result;
    logic    r_in_ready;
    logic    r_out_valid;
    logic    w_accept;
    logic    w_drain;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_drain  = r_out_valid & bus.out_ready;

    exec_result_stage_branch_resolver u_branch_resolver (
        .i_kind     (bus.in_kind),
        .i_funct3   (bus.in_funct3),
        .i_alu_comp (bus.in_alu_comp),
        .i_alu_dout (bus.in_alu_dout),
        .i_pc       (bus.in_pc),
        .i_imm      (bus.in_imm),
        .i_rd       (bus.in_rd),
        .o_result_c (w_result)
    );

    // Ready/valid are registered decodes of the next state, so in_ready has
    // no combinational path from out_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_nxt  = w_result;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_accept && w_drain) begin
                    w_main_nxt = w_result;
                end else if (w_accept) begin
                    w_skid_nxt  = w_result;
                    w_state_nxt = ST_FULL;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_rd_en      = r_main.rd_en;
    assign bus.out_rd_addr    = r_main.rd_addr;
    assign bus.out_rd_din     = r_main.rd_din;
    assign bus.out_redirect   = r_main.redirect;
    assign bus.out_target     = r_main.target;
    assign bus.out_misaligned = r_main.misaligned;

endmodule

// File: tb/tb_exec_result_stage.sv
// Self-checking bench for exec_result_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_exec_result_stage;
    import exec_result_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exec_result_stage_if bus();

    exec_result_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    result_t got;
    result_t q[$];

    always_comb got = {bus.out_rd_en, bus.out_rd_addr, bus.out_rd_din,
                       bus.out_redirect, bus.out_target, bus.out_misaligned};

    // Reference: result of one instruction from the architectural rules
    function automatic result_t model(input logic [1:0] kind, input logic [2:0] f3,
                                      input logic [2:0] comp, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic [31:0] alu,
                                      input logic [4:0] rd);
        result_t r;
        logic    eq, lt, ltu, taken;
        longint  sum;
        r = '0;
        eq = comp[0];
        lt = comp[1];
        ltu = comp[2];
        r.rd_addr = rd;
        if (kind == 2'd1) begin
            r.rd_en  = (rd != 5'd0);
            r.rd_din = alu;
        end else if (kind == 2'd2) begin
            case (f3)
                3'd0: taken = eq;
                3'd1: taken = !eq;
                3'd4: taken = lt;
                3'd5: taken = !lt;
                3'd6: taken = ltu;
                3'd7: taken = !ltu;
                default: taken = 1'b0;
            endcase
            sum = longint'(pc) + longint'(imm);
            r.redirect = taken;
            r.target   = 32'(sum % 64'h1_0000_0000);
        end else if (kind == 2'd3) begin
            sum = longint'(pc) + 64'd4;
            r.rd_en    = (rd != 5'd0);
            r.rd_din   = 32'(sum % 64'h1_0000_0000);
            r.redirect = 1'b1;
            r.target   = alu - 32'(alu % 2);
        end
        r.misaligned = r.redirect && ((r.target % 4) != 0);
        return r;
    endfunction

    function automatic result_t model_cur();
        return model(bus.in_kind, bus.in_funct3, bus.in_alu_comp, bus.in_pc,
                     bus.in_imm, bus.in_alu_dout, bus.in_rd);
    endfunction

    task automatic set_in(input logic [1:0] kind, input logic [2:0] f3, input logic [2:0] comp,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic [4:0] rd);
        bus.in_kind = kind;
        bus.in_funct3 = f3;
        bus.in_alu_comp = comp;
        bus.in_pc = pc;
        bus.in_imm = imm;
        bus.in_alu_dout = alu;
        bus.in_rd = rd;
    endtask

    task automatic rand_in();
        logic [31:0] imm;
        imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
        set_in(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), $urandom, imm,
               $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_in(2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++;
        if (got !== result_t'(0)) begin errors++; $display("FAIL reset_payload got=%h exp=0", got); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        set_in(2'd1, 3'd0, 3'd0, 32'h40, 32'd0, 32'h1234, 5'd5);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL alu_latency got=%b exp=1", bus.out_valid); end
        checks++;
        if (got !== result_t'({1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b0}))
            begin errors++; $display("FAIL alu_payload got=%h exp rd_en=1 rd=5 din=1234", got); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_branch();
        result_t exp;
        bus.out_ready = 1'b1;
        for (int e = 0; e < 2; e++) begin
            set_in(2'd2, 3'b001, (e == 0) ? 3'b000 : 3'b001, 32'h100, 32'hFFFF_FFF8, 32'h55, 5'd7);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            exp = result_t'({1'b0, 5'd7, 32'h0, (e == 0), 32'hF8, 1'b0});
            checks++;
            if (bus.out_valid !== 1'b1 || got !== exp)
                begin errors++; $display("FAIL bne_eq%0d got=%h exp=%h", e, got, exp); end
            tick();
        end
        // Every funct3 against every flag combination, back to back
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            set_in(2'd2, 3'(i / 8), 3'(i % 8), $urandom, $urandom, $urandom, 5'($urandom));
            exp = model_cur();
            tick();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL branch_f3_%0d_comp_%0d got=%h exp=%h", i / 8, i % 8, got, exp); end
            if (i / 8 == 2 || i / 8 == 3) begin
                checks++;
                if (bus.out_redirect !== 1'b0)
                    begin errors++; $display("FAIL branch_reserved_f3_%0d redirect got=%b exp=0", i / 8, bus.out_redirect); end
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_jump();
        set_in(2'd3, 3'd0, 3'd0, 32'hFFFF_FFFC, 32'h10, 32'h203, 5'd1);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (got !== result_t'({1'b1, 5'd1, 32'h0, 1'b1, 32'h202, 1'b1}))
            begin errors++; $display("FAIL jump_wrap got=%h exp din=0 tgt=202 mis=1", got); end
        tick();
    endtask

    task automatic test_rd_zero();
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k += 2) begin
            set_in(2'(k), 3'd0, 3'd0, 32'h200, 32'd0, 32'h400, 5'd0);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_rd_en !== 1'b0)
                begin errors++; $display("FAIL rd_zero_kind%0d rd_en got=%b exp=0", k, bus.out_rd_en); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int drained;
        q.delete();
        drained = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(2'd1, 3'd0, 3'd0, 32'h0, 32'h0, 32'hA000 + 32'(i), 5'(10 + i));
            bus.in_valid = 1'b1;
            if (bus.in_ready) q.push_back(model_cur());
            tick();
        end
        checks++;
        if (bus.in_ready !== 1'b0 || q.size() != 2)
            begin errors++; $display("FAIL bp_full in_ready got=%b exp=0 accepted=%0d exp=2", bus.in_ready, q.size()); end
        for (int h = 0; h < 3; h++) begin
            bus.in_alu_dout = $urandom;
            tick();
            checks++;
            if (got !== q[0]) begin errors++; $display("FAIL bp_hold got=%h exp=%h", got, q[0]); end
        end
        bus.in_alu_dout = 32'hA002;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && (bus.in_valid || q.size() > 0); c++) begin
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0 || got !== q[0])
                    begin errors++; $display("FAIL bp_order got=%h exp=%h", got, (q.size() > 0) ? q[0] : result_t'(0)); end
                if (q.size() > 0) void'(q.pop_front());
                drained++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model_cur());
                tick();
                bus.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        checks++;
        if (drained != 3 || q.size() != 0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_count drained=%0d exp=3 left=%0d", drained, q.size()); end
    endtask

    task automatic test_random();
        q.delete();
        for (int c = 0; c < 600; c++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            rand_in();
            bus.out_ready = ($urandom_range(0, 9) < 6);
            checks++;
            if (bus.in_ready !== (q.size() < 2))
                begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b occ=%0d", c, bus.in_ready, q.size()); end
            checks++;
            if (bus.out_valid !== (q.size() > 0))
                begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b occ=%0d", c, bus.out_valid, q.size()); end
            if (q.size() > 0) begin
                checks++;
                if (got !== q[0]) begin errors++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, got, q[0]); end
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) q.push_back(model_cur());
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || got !== q[0])
                begin errors++; $display("FAIL rnd_drain got=%h exp=%h", got, q[0]); end
            void'(q.pop_front());
            tick();
        end
        checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL rnd_final left=%0d out_valid=%b", q.size(), bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        result_t exp;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(2'd3, 3'd0, 3'd0, 32'h1000, 32'd0, 32'h2001 + 32'(i * 4), 5'd3);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full in_ready got=%b exp=0", bus.in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL mid_async out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
        checks++;
        if (got !== result_t'(0)) begin errors++; $display("FAIL mid_clear got=%h exp=0", got); end
        #2;
        rst = 1'b1;
        tick();
        set_in(2'd1, 3'd0, 3'd0, 32'h0, 32'h0, 32'hBEEF, 5'd9);
        exp = model_cur();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || got !== exp)
            begin errors++; $display("FAIL mid_after got=%h valid=%b exp=%h", got, bus.out_valid, exp); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_dup out_valid got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_rd_zero();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_result_stage.md
Name: exec_result_stage

Overview:
- Sits directly downstream of the ALU in the execute path and consumes its data output, its comparison flags, and the instruction context (pc, imm, rd, kind, funct3).
- Resolves branches and jumps, builds the register-file write and the PC redirect, and presents one registered result beat per instruction to writeback/fetch.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the ALU side sees a registered in_ready and never loses a beat.

Parameters:
DATA_WIDTH, 32, data/PC width (shared `DATA_WIDTH)
REG_WIDTH, 5, register address width
KIND_WIDTH, 2, instruction-kind encoding width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat (registered)
in_alu_dout  input  DATA_WIDTH  ALU result
in_alu_comp  input  `ALU_COMP_WIDTH  {ltu,lt,eq} flags indexed by `ALU_COMP_EQ/LT/LTU
in_pc  input  DATA_WIDTH  instruction PC
in_imm  input  DATA_WIDTH  sign-extended immediate
in_rd  input  REG_WIDTH  destination register
in_kind  input  KIND_WIDTH  0=NONE, 1=ALU, 2=BRANCH, 3=JUMP
in_funct3  input  3  branch condition select
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts beat
out_rd_en  output  1  register write enable
out_rd_addr  output  REG_WIDTH  register write address
out_rd_din  output  DATA_WIDTH  register write data
out_redirect  output  1  PC redirect for this beat
out_target  output  DATA_WIDTH  redirect target
out_misaligned  output  1  redirect target[1:0] != 0 (exception to control)

Behaviour:
- Reset (rst=0, async): state EMPTY; out_valid=0; in_ready=1; every other output and both buffer entries cleared to 0.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- FSM:
  - EMPTY: accept -> BUSY (main register loaded).
  - BUSY: accept & drain -> BUSY (main reloaded); accept & !drain -> FULL (beat goes to skid); !accept & drain -> EMPTY.
  - FULL: in_ready=0; drain -> BUSY (skid moves to main).
- in_ready=0 only in FULL; it is a flop output, not a combinational path from out_ready.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1 when the buffer is empty. Order is strictly FIFO.
- out_* hold stable while out_valid & !out_ready. out_valid=0 in EMPTY. Payload outputs are don't-care-stable (hold last value) when out_valid=0.
- Result computation (combinational on input; registered into buffer):
  - ALU: rd_en=1, rd_din=alu_dout, redirect=0.
  - BRANCH: taken per funct3. 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never taken. rd_en=0. redirect=taken. target=pc+imm (mod 2^DATA_WIDTH).
  - JUMP: rd_en=1, rd_din=pc+4, redirect=1, target=alu_dout & ~1 (ALU supplies pc+imm or rs1+imm).
  - NONE: rd_en=0, redirect=0, target=0.
- rd_en forced 0 when rd==0.
- misaligned = redirect & (target[1:0]!=0); when misaligned is set, redirect still asserted (control decides the trap).
- Arithmetic wraps: pc+4 and pc+imm truncate to DATA_WIDTH.
- Reset mid-operation: buffered beats are discarded, no partial output; first beat after release is accepted normally.
- in_* may change arbitrarily while in_ready=0; they are sampled only on accept.

Decomposition:
- Add to copperv_h.v: KIND_* codes and KIND_WIDTH; BR_FUNCT3_* codes (BEQ, BNE, BLT, BGE, BLTU, BGEU); RESULT_WIDTH (packed rd_en+rd_addr+rd_din+redirect+target+misaligned).
- One sub-module: branch_resolver, combinational, mapping kind/funct3/alu_comp/pc/imm/alu_dout/rd to the packed result. The stage module holds the FSM and two RESULT_WIDTH registers.

Test Plan:
- ALU beat alu_dout=0x1234, rd=5, out_ready=1 -> next cycle out_valid=1, rd_en=1, rd_addr=5, rd_din=0x1234, redirect=0.
- BRANCH funct3=001, comp.eq=0, pc=0x100, imm=-8 -> redirect=1, target=0xF8, rd_en=0. Same beat with eq=1 -> redirect=0.
- JUMP pc=0xFFFFFFFC, alu_dout=0x203, rd=1 -> rd_din=0x0, target=0x202, misaligned=1.
- Backpressure: 3 back-to-back beats A,B,C with out_ready=0 -> A on output, B in skid, in_ready=0 and C held upstream. Then out_ready=1 -> A, B, C drain in order with no loss or duplication.
- rd=0 ALU beat -> rd_en=0. Branch funct3=010 with every flag combination -> never redirects.
- Assert rst low while FULL -> out_valid=0 and in_ready=1 immediately (async). After release, a new beat emerges with latency 1.
